ic_capture_ctrl: RTL

Input-capture channel controller for one general-purpose timer channel. Decodes the 4-bit ICF filter code into a sampling strobe and event count for the channel's digital filter. Detects qualifying edges on the filtered input, applies polarity and the capture prescaler, and latches the timer counter into the capture register. Maintains the capture (CCxIF) and overcapture (CCxOF) flags. It sits between the channel's digital filter and the timer's register file.

---
 rtl/ic_capture_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ic_capture_ctrl.sv
// ic_capture_ctrl: input-capture channel controller for one timer channel.
// Decodes the ICF filter code into a sampling strobe and sample count, detects
// qualifying edges on the filtered input, applies the capture prescaler and
// latches the timer counter into the capture register with CCxIF/CCxOF flags.
// Build option: define IC_OVERCAPTURE_EN to build the overcapture flag;
// without it ccof_o is tied low and ccof_clr_i is ignored.
module ic_capture_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       icf_i,
  input  logic             af_i,
  input  logic             cce_i,
  input  logic             ccp_i,
  input  logic             ccnp_i,
  input  logic [1:0]       psc_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             ccif_clr_i,
  input  logic             ccof_clr_i,
  output logic             sample_en_o,
  output logic [3:0]       filt_n_o,
  output logic [CNT_W-1:0] ccr_o,
  output logic             ccif_o,
  output logic             ccof_o
);

  logic [4:0] div_m1;
  logic [4:0] div_cnt;
  logic [3:0] icf_q;
  logic [1:0] psc_q;
  logic       af_q;
  logic [2:0] ev_cnt;
  logic [2:0] ev_last;
  logic       rise;
  logic       fall;
  logic       evt_sel;
  logic       evt;
  logic       cap;

  // ICF code -> (divisor-1, consecutive-sample count)
  always_comb begin
    div_m1   = 5'd0;
    filt_n_o = 4'd1;
    case (icf_i)
      4'd0:  begin div_m1 = 5'd0;  filt_n_o = 4'd1; end
      4'd1:  begin div_m1 = 5'd0;  filt_n_o = 4'd2; end
      4'd2:  begin div_m1 = 5'd0;  filt_n_o = 4'd4; end
      4'd3:  begin div_m1 = 5'd0;  filt_n_o = 4'd8; end
      4'd4:  begin div_m1 = 5'd1;  filt_n_o = 4'd6; end
      4'd5:  begin div_m1 = 5'd1;  filt_n_o = 4'd8; end
      4'd6:  begin div_m1 = 5'd3;  filt_n_o = 4'd6; end
      4'd7:  begin div_m1 = 5'd3;  filt_n_o = 4'd8; end
      4'd8:  begin div_m1 = 5'd7;  filt_n_o = 4'd6; end
      4'd9:  begin div_m1 = 5'd7;  filt_n_o = 4'd8; end
      4'd10: begin div_m1 = 5'd15; filt_n_o = 4'd5; end
      4'd11: begin div_m1 = 5'd15; filt_n_o = 4'd6; end
      4'd12: begin div_m1 = 5'd15; filt_n_o = 4'd8; end
      4'd13: begin div_m1 = 5'd31; filt_n_o = 4'd5; end
      4'd14: begin div_m1 = 5'd31; filt_n_o = 4'd6; end
      default: begin div_m1 = 5'd31; filt_n_o = 4'd8; end
    endcase
  end

  // Sampling divider; restarts whenever the filter code changes.
  // icf_q loads the live code during reset so the first cycle out of reset
  // is not mistaken for a code change.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt <= 5'd0;
      icf_q   <= icf_i;
    end else begin
      icf_q <= icf_i;
      if ((icf_i != icf_q) || (div_cnt == div_m1)) div_cnt <= 5'd0;
      else                                         div_cnt <= div_cnt + 5'd1;
    end
  end

  assign sample_en_o = (div_cnt == div_m1);

  assign rise = af_i & ~af_q;
  assign fall = ~af_i & af_q;

  // Polarity selection; the reserved 10 code behaves as rising-edge.
  always_comb begin
    evt_sel = rise;
    case ({ccnp_i, ccp_i})
      2'b01:   evt_sel = fall;
      2'b11:   evt_sel = rise | fall;
      default: evt_sel = rise;
    endcase
  end

  assign evt     = cce_i & evt_sel;
  assign ev_last = 3'((4'd1 << psc_i) - 4'd1);
  assign cap     = evt & (ev_cnt == ev_last);

  // Edge-detect history and capture prescaler
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      af_q   <= 1'b0;
      psc_q  <= psc_i;
      ev_cnt <= 3'd0;
    end else begin
      af_q  <= af_i;
      psc_q <= psc_i;
      if (!cce_i || (psc_i != psc_q) || cap) ev_cnt <= 3'd0;
      else if (evt)                          ev_cnt <= ev_cnt + 3'd1;
    end
  end

  // Capture register and capture flag; a set wins over a same-cycle clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ccr_o  <= '0;
      ccif_o <= 1'b0;
    end else begin
      if (cap) ccr_o <= cnt_i;
      if (cap)             ccif_o <= 1'b1;
      else if (ccif_clr_i) ccif_o <= 1'b0;
    end
  end

`ifdef IC_OVERCAPTURE_EN
  // Overcapture: capture while the previous one is still unacknowledged
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ccof_o <= 1'b0;
    end else begin
      if (cap && ccif_o && !ccif_clr_i) ccof_o <= 1'b1;
      else if (ccof_clr_i)              ccof_o <= 1'b0;
    end
  end
`else
  logic unused_ccof_clr;
  assign unused_ccof_clr = ccof_clr_i;
  assign ccof_o = 1'b0;
`endif

endmodule
